// File: rtl/logical_r_shift_seq.sv
// Multi-cycle logical right shifter: one log-shifter stage per clock, valid/ready on both sides.
// Define LOGICAL_R_SHIFT_ARITH_EN to add the 'arith' input for sign-filling shifts.
module logical_r_shift_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [31:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef LOGICAL_R_SHIFT_ARITH_EN
  ,
  input  logic             arith
`endif
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] LAST = (SHW+1)'(SHW);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic             ovf;
  logic [SHW:0]     stage;
  logic             fill;

  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] fillmask;
  logic [WIDTH-1:0] shifted;

`ifdef LOGICAL_R_SHIFT_ARITH_EN
  logic arith_q;
  logic sign_q;
  assign fill = arith_q & sign_q;
`else
  assign fill = 1'b0;
`endif

  always_comb begin
    amt      = SHW'(1) << stage;
    fillmask = ~({WIDTH{1'b1}} >> amt);
    shifted  = (acc >> amt) | (fillmask & {WIDTH{fill}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      stage     <= '0;
`ifdef LOGICAL_R_SHIFT_ARITH_EN
      arith_q   <= 1'b0;
      sign_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= a;
            cnt      <= b[SHW-1:0];
            ovf      <= |b[31:SHW];
            stage    <= '0;
`ifdef LOGICAL_R_SHIFT_ARITH_EN
            arith_q  <= arith;
            sign_q   <= a[WIDTH-1];
`endif
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          // cnt is consumed LSB-first so cnt[0] always holds the bit for the current stage;
          // the extra cycle at stage==LAST registers the result, giving a fixed SHW+1 latency.
          if (stage == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= acc;
          end else begin
            if (ovf)
              acc <= {WIDTH{fill}};
            else if (cnt[0])
              acc <= shifted;
            cnt   <= cnt >> 1;
            stage <= stage + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logical_r_shift_seq.sv
// Bench for logical_r_shift_seq: directed steps plus random traffic against a queued reference.
// Arith cases are compiled in when LOGICAL_R_SHIFT_ARITH_EN is defined.
module tb_logical_r_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
`ifdef LOGICAL_R_SHIFT_ARITH_EN
  logic        arith;
`endif

  logic [31:0] sb[$];
  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;
  int          acc_cyc = 0;
  int          n_acc  = 0;
  logic        ov_prev = 1'b0;

  logical_r_shift_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
`ifdef LOGICAL_R_SHIFT_ARITH_EN
    ,
    .arith     (arith)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [31:0] av, input logic [31:0] bv, input logic ar);
    logic [31:0] fillv;
    fillv = (ar && av[31]) ? 32'hFFFF_FFFF : 32'h0;
    if (bv >= 32) return fillv;
    return (av >> bv[4:0]) | (fillv & ~(32'hFFFF_FFFF >> bv[4:0]));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Monitor: handshakes seen at the negedge complete on the following posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        logic ar;
        ar = 1'b0;
`ifdef LOGICAL_R_SHIFT_ARITH_EN
        ar = arith;
`endif
        sb.push_back(model(a, b, ar));
        acc_cyc = cyc + 1;
        n_acc++;
      end
      if (out_valid && !ov_prev)
        check("latency", 32'(cyc - acc_cyc), 32'd6);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          $error("FAIL unexpected_output: observed %h expected none", result);
        end else begin
          check("sb_result", result, sb.pop_front());
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic ar);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    a = av; b = bv; in_valid = 1'b1;
`ifdef LOGICAL_R_SHIFT_ARITH_EN
    arith = ar;
`else
    if (ar) $display("note: arith request ignored in this build");
`endif
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_out();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
    end
    check("out_timeout", {31'd0, got}, 32'd1);
  endtask

  initial begin
    int n_ov;
    int target;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
`ifdef LOGICAL_R_SHIFT_ARITH_EN
    arith = 1'b0;
`endif
    #23;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_result",    result,             32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset mid-SHIFT discards the operation
    issue(32'hFFFF_FFFF, 32'd4, 1'b0);
    @(posedge clk); #1;
    check("shift_busy",     {31'd0, busy},     32'd1);
    check("shift_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result",    result,             32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    check("midrst_busy",      {31'd0, busy},      32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    n_ov = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) n_ov++;
    end
    check("midrst_no_output", 32'(n_ov), 32'd0);

    // Basic shift, handoff and in_ready return
    out_ready = 1'b1;
    issue(32'h8000_0000, 32'd31, 1'b0);
    wait_out();
    check("basic_result", result, 32'h0000_0001);
    @(negedge clk);
    check("basic_in_ready",  {31'd0, in_ready},  32'd1);
    check("basic_out_valid", {31'd0, out_valid}, 32'd0);

    // Zero count and overflow counts
    issue(32'h1234_5678, 32'd0, 1'b0);
    wait_out();
    check("b0_result", result, 32'h1234_5678);
    issue(32'hDEAD_BEEF, 32'd32, 1'b0);
    wait_out();
    check("b32_result", result, 32'h0);
    issue(32'hDEAD_BEEF, 32'h0000_0100, 1'b0);
    wait_out();
    check("b256_result", result, 32'h0);
    issue(32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0);
    wait_out();
    check("bmax_result", result, 32'h0);
    @(negedge clk);

    // Backpressure: result held, new operands refused
    out_ready = 1'b0;
    issue(32'hF0F0_F0F0, 32'd4, 1'b0);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin in_valid = 1'b1; a = 32'h1111_1111; b = 32'd1; end
      @(negedge clk);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_result",    result,             32'h0F0F_0F0F);
      check("stall_in_ready",  {31'd0, in_ready},  32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check("stall_drained", 32'(sb.size()), 32'd0);

`ifdef LOGICAL_R_SHIFT_ARITH_EN
    issue(32'h8000_0000, 32'd4, 1'b1);
    wait_out();
    check("arith_b4", result, 32'hF800_0000);
    issue(32'h8000_0000, 32'd40, 1'b1);
    wait_out();
    check("arith_b40", result, 32'hFFFF_FFFF);
    issue(32'h8000_0000, 32'd4, 1'b0);
    wait_out();
    check("logic_b4", result, 32'h0800_0000);
    issue(32'h8000_0000, 32'd40, 1'b0);
    wait_out();
    check("logic_b40", result, 32'h0);
    @(negedge clk);
`endif

    // Random traffic with random valid/ready
    target = n_acc + 2000;
    for (int i = 0; i < 60000; i++) begin
      @(posedge clk); #1;
      if (n_acc >= target) break;
      in_valid  = 1'($urandom_range(0, 1));
      a         = $urandom;
      b         = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef LOGICAL_R_SHIFT_ARITH_EN
      arith     = 1'($urandom_range(0, 1));
`endif
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("rand_accepted", {31'd0, n_acc >= target}, 32'd1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    @(negedge clk);
    check("rand_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
